// File: rtl/uart_pkg.sv
// Shared definitions for the UART result-bus transmitter.
// Optional feature macro: UART_TX_PARITY_EN. When it is defined, frame bit
// BITS_PER_WORD+1 carries even parity over the data bits. The frame length
// does not change.
package uart_pkg;

    // Fixed frame geometry, shared with the host-side monitor
    localparam int BITS_PER_WORD  = 8;
    localparam int PACKET_SIZE_TX = 13;

    // Defaults for the top-level parameters (simulation values)
    localparam int DEFAULT_CLOCKS_PER_PULSE = 4;
    localparam int DEFAULT_W_BUS            = 128;

    // Positions of fields inside a frame vector
    localparam int START_IDX    = 0;
    localparam int DATA_LSB_IDX = 1;
    localparam int PARITY_IDX   = BITS_PER_WORD + 1;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // Build the complete frame for one data word. Bit 0 goes on the line first.
    // Every bit that is not the start bit, a data bit or the parity bit idles high.
    function automatic logic [PACKET_SIZE_TX-1:0] frame_f(input logic [BITS_PER_WORD-1:0] word);
        logic [PACKET_SIZE_TX-1:0] f;
        f                                 = '1;
        f[START_IDX]                      = 1'b0;
        f[DATA_LSB_IDX +: BITS_PER_WORD]  = word;
`ifdef UART_TX_PARITY_EN
        f[PARITY_IDX]                     = ^word;
`endif
        return f;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer. It counts 0..CLOCKS_PER_PULSE-1 while enabled and raises
// bit_end for one cycle on the last count of each bit period. The clear input
// holds the count at zero so that the next period starts aligned.
module uart_baud_tick #(
    parameter int CLOCKS_PER_PULSE = 4
) (
    input  logic clk,
    input  logic rstn,
    input  logic clear,
    input  logic en,
    output logic bit_end
);

    localparam int CNT_W = (CLOCKS_PER_PULSE > 1) ? $clog2(CLOCKS_PER_PULSE) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLOCKS_PER_PULSE - 1);

    logic [CNT_W-1:0] cnt;

    // Pulse counter: wraps at the end of each bit period and is held at zero while cleared
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (en) begin
            if (cnt == LAST) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign bit_end = en && !clear && (cnt == LAST);

endmodule

// File: rtl/uart_bus_tx.sv
// Serializes a W_BUS-wide result bus into N_WORDS back-to-back UART frames.
// Word 0 (bits [BITS_PER_WORD-1:0]) goes first, and each word is sent LSB first.
// Optional feature macro: UART_TX_PARITY_EN (even parity bit after the data bits).
module uart_bus_tx
    import uart_pkg::*;
#(
    parameter int CLOCKS_PER_PULSE = DEFAULT_CLOCKS_PER_PULSE,
    parameter int W_BUS            = DEFAULT_W_BUS
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [W_BUS-1:0] s_data,
    output logic             tx,
    output logic             busy
);

    localparam int N_WORDS = W_BUS / BITS_PER_WORD;
    localparam int WORD_W  = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
    localparam int BIT_W   = $clog2(PACKET_SIZE_TX);

    localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(N_WORDS - 1);
    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(PACKET_SIZE_TX - 1);

    state_t                    state;
    logic [W_BUS-1:0]          bus_reg;    // words still to send; the next word sits in the low byte
    logic [PACKET_SIZE_TX-2:0] frame_reg;  // bits of the current frame still to put on the line
    logic [WORD_W-1:0]         word_cnt;
    logic [BIT_W-1:0]          bit_cnt;
    logic                      bit_end;

    logic [PACKET_SIZE_TX-1:0] first_frame;
    logic [PACKET_SIZE_TX-1:0] next_frame;

    assign first_frame = frame_f(s_data[BITS_PER_WORD-1:0]);
    assign next_frame  = frame_f(bus_reg[BITS_PER_WORD-1:0]);

    uart_baud_tick #(
        .CLOCKS_PER_PULSE (CLOCKS_PER_PULSE)
    ) u_baud (
        .clk     (clk),
        .rstn    (rstn),
        .clear   (state == IDLE),
        .en      (state == SEND),
        .bit_end (bit_end)
    );

    // Transmit FSM: latches the bus, then walks the word and bit counters, driving tx from a register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            tx        <= 1'b1;
            s_ready   <= 1'b1;
            busy      <= 1'b0;
            word_cnt  <= '0;
            bit_cnt   <= '0;
            bus_reg   <= '0;
            frame_reg <= '1;
        end else begin
            case (state)
                IDLE: begin
                    tx       <= 1'b1;
                    word_cnt <= '0;
                    bit_cnt  <= '0;
                    if (s_valid && s_ready) begin
                        // The start bit of word 0 goes out on the acceptance edge
                        bus_reg   <= s_data >> BITS_PER_WORD;
                        tx        <= first_frame[0];
                        frame_reg <= first_frame[PACKET_SIZE_TX-1:1];
                        s_ready   <= 1'b0;
                        busy      <= 1'b1;
                        state     <= SEND;
                    end
                end
                SEND: begin
                    if (bit_end) begin
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt <= '0;
                            if (word_cnt == LAST_WORD) begin
                                word_cnt <= '0;
                                tx       <= 1'b1;
                                busy     <= 1'b0;
                                s_ready  <= 1'b1;
                                state    <= IDLE;
                            end else begin
                                // The next frame starts with no idle gap
                                word_cnt  <= word_cnt + 1'b1;
                                tx        <= next_frame[0];
                                frame_reg <= next_frame[PACKET_SIZE_TX-1:1];
                                bus_reg   <= bus_reg >> BITS_PER_WORD;
                            end
                        end else begin
                            bit_cnt   <= bit_cnt + 1'b1;
                            tx        <= frame_reg[0];
                            frame_reg <= {1'b1, frame_reg[PACKET_SIZE_TX-2:1]};
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
